poly1305_tag: RTL and testbench

Multi-cycle Poly1305 one-time authenticator (RFC 8439) for the ChaCha20-Poly1305 datapath. On a start pulse it pulls the 128-bit key halves r and s, then the message in 128-bit words, through a request/enable handshake. It computes the 128-bit tag with a 32-bit-limb accumulate/multiply/reduce engine and signals completion.

---
 rtl/poly1305_tag.sv | 130 +++++++++++++
 tb/tb_poly1305_tag.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poly1305_tag.sv
// Poly1305 one-time authenticator (RFC 8439). Key halves r, s and the message
// are pulled one 128-bit word at a time; 32-bit limb accumulate/multiply/reduce.
module poly1305_tag (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic         i_en_msg,
  input  logic [127:0] i_msg,
  input  logic [31:0]  i_len_msg,
  output logic         o_rqst_msg,
  output logic [127:0] o_tag,
  output logic         o_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_KEY_R, S_KEY_S, S_RQST, S_ADD, S_MUL, S_MOD, S_FINAL, S_ADD_S, S_DONE
  } state_t;

  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

  state_t        state, state_nx;
  logic          rqst_nx;
  logic          take;
  logic [127:0]  r_q, s_q, msg_q;
  logic [31:0]   len_q;
  logic [28:0]   blocks_left;
  logic [159:0]  acc;
  logic [255:0]  prod_q;

  logic [32:0]   len_p15;
  logic          last_partial;
  logic [4:0]    nbytes;
  logic [128:0]  pad, blk;
  logic [255:0]  prod_c;
  logic [130:0]  f1, f2, g;

  assign take   = o_rqst_msg & i_en_msg;
  assign o_done = (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Each request is a fresh rising edge: entering a request state with the
  // line low costs one cycle before it is raised.
  always_comb begin
    state_nx = state;
    rqst_nx  = o_rqst_msg;
    case (state)
      S_IDLE: if (i_start) begin
        state_nx = S_KEY_R;
        rqst_nx  = 1'b1;
      end
      S_KEY_R, S_KEY_S, S_RQST: begin
        if (!o_rqst_msg) begin
          rqst_nx = 1'b1;
        end else if (i_en_msg) begin
          rqst_nx = 1'b0;
          if (state == S_KEY_R)      state_nx = S_KEY_S;
          else if (state == S_KEY_S) state_nx = (len_q == 32'd0) ? S_FINAL : S_RQST;
          else                       state_nx = S_ADD;
        end
      end
      S_ADD:   state_nx = S_MUL;
      S_MUL:   state_nx = S_MOD;
      S_MOD:   state_nx = (blocks_left == 29'd1) ? S_FINAL : S_RQST;
      S_FINAL: state_nx = S_ADD_S;
      S_ADD_S: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    len_p15      = {1'b0, i_len_msg} + 33'd15;
    last_partial = (blocks_left == 29'd1) && (len_q[3:0] != 4'd0);
    nbytes       = last_partial ? {1'b0, len_q[3:0]} : 5'd16;
    pad          = 129'd1 << {nbytes, 3'b000};
    blk          = ({1'b0, msg_q} & (pad - 129'd1)) | pad;

    prod_c = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        prod_c = prod_c + (256'(64'(acc[32*i +: 32]) * 64'(r_q[32*j +: 32])) << (32*(i+j)));
      end
    end

    // Two folds with 2^130 == 5 leave the value below 2^130 + 5.
    f1 = {1'b0, prod_q[129:0]} + ({5'b0, prod_q[255:130]} * 131'd5);
    f2 = {1'b0, f1[129:0]} + (f1[130] ? 131'd5 : 131'd0);
    g  = acc[130:0] + 131'd5;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rqst_msg  <= 1'b0;
      o_tag       <= '0;
      r_q         <= '0;
      s_q         <= '0;
      msg_q       <= '0;
      len_q       <= '0;
      blocks_left <= '0;
      acc         <= '0;
      prod_q      <= '0;
    end else begin
      o_rqst_msg <= rqst_nx;
      case (state)
        S_IDLE: if (i_start) begin
          len_q       <= i_len_msg;
          blocks_left <= len_p15[32:4];
          acc         <= '0;
        end
        S_KEY_R: if (take) r_q   <= i_msg & CLAMP;
        S_KEY_S: if (take) s_q   <= i_msg;
        S_RQST:  if (take) msg_q <= i_msg;
        S_ADD:   acc    <= acc + {31'b0, blk};
        S_MUL:   prod_q <= prod_c;
        S_MOD: begin
          acc         <= {29'b0, f2};
          blocks_left <= blocks_left - 29'd1;
        end
        S_FINAL: if (g[130]) acc <= {30'b0, g[129:0]};
        S_ADD_S: o_tag <= acc[127:0] + s_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly1305_tag.sv
// Bench for poly1305_tag: RFC vectors, handshake corner cases and random runs
// checked against a big-integer Poly1305 model.
module tb_poly1305_tag;

  localparam logic [127:0] CLAMP   = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  localparam logic [127:0] RFC_R   = 128'ha806d542_fe52447f_336d5557_78bed685;
  localparam logic [127:0] RFC_S   = 128'h1bf54941_aff6bf4a_fdb20dfb_8a800301;
  localparam logic [127:0] RFC_TAG = 128'ha927010c_af8b2bc2_c6365130_c11d06a8;

  logic         i_clk = 1'b0, i_rstn = 1'b1, i_start = 1'b0, i_en_msg = 1'b0;
  logic [127:0] i_msg = '0;
  logic [31:0]  i_len_msg = '0;
  logic         o_rqst_msg, o_done;
  logic [127:0] o_tag;

  int n_pass = 0, n_chk = 0;
  int rq_rise = 0, done_cnt = 0;
  logic rq_prev = 1'b0;
  logic [127:0] wbuf [16];

  always #5 i_clk = ~i_clk;

  poly1305_tag dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_en_msg(i_en_msg),
    .i_msg(i_msg), .i_len_msg(i_len_msg), .o_rqst_msg(o_rqst_msg),
    .o_tag(o_tag), .o_done(o_done)
  );

  always @(negedge i_clk) begin
    if (o_rqst_msg && !rq_prev) rq_rise++;
    if (o_done) done_cnt++;
    rq_prev = o_rqst_msg;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] model_tag(input logic [127:0] r, input logic [127:0] s, input int len);
    logic [287:0] acc, n, rr, p;
    int k;
    rr  = {160'b0, r & CLAMP};
    p   = (288'd1 << 130) - 288'd5;
    acc = '0;
    for (int b = 0; b < (len + 15) / 16; b++) begin
      k = len - 16 * b;
      if (k > 16) k = 16;
      n   = 288'd1 << (8 * k);
      acc = ((acc + (({160'b0, wbuf[b]}) & (n - 288'd1)) + n) * rr) % p;
    end
    return 128'(acc + {160'b0, s});
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_rfc();
    wbuf[0] = 128'h6f462063_69687061_72676f74_70797243;
    wbuf[1] = 128'h6f724720_68637261_65736552_206d7572;
    wbuf[2] = 128'h00000000_00000000_00000000_00007075;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_en_msg = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic start_run(input int len);
    i_start = 1'b1; i_len_msg = len;
    @(negedge i_clk);
    i_start = 1'b0; i_len_msg = $urandom;
  endtask

  task automatic feed_word(input logic [127:0] w, input int dly, output bit ok, output bit dropped);
    int cyc = 0;
    ok = 1'b1; dropped = 1'b0;
    while (!o_rqst_msg) begin
      if (cyc >= 100) begin ok = 1'b0; return; end
      @(negedge i_clk);
      cyc++;
    end
    for (int d = 0; d < dly; d++) begin
      @(negedge i_clk);
      if (!o_rqst_msg) dropped = 1'b1;
    end
    i_en_msg = 1'b1; i_msg = w;
    @(negedge i_clk);
    i_en_msg = 1'b0; i_msg = rnd128();
  endtask

  // Drives one complete computation; the inject option adds a stray i_en_msg
  // and i_start while the block is busy processing the first message word.
  task automatic run_tag(input logic [127:0] r, input logic [127:0] s, input int len,
                         input int dmin, input int dmax, input bit inject,
                         output logic [127:0] tag, output bit ok, output bit dropped,
                         output bit one_pulse);
    bit fok, fdrop;
    int cyc;
    ok = 1'b1; dropped = 1'b0; one_pulse = 1'b0; tag = '0;
    start_run(len);
    feed_word(r, int'($urandom_range(dmax, dmin)), fok, fdrop); ok &= fok; dropped |= fdrop;
    feed_word(s, int'($urandom_range(dmax, dmin)), fok, fdrop); ok &= fok; dropped |= fdrop;
    for (int b = 0; b < (len + 15) / 16; b++) begin
      feed_word(wbuf[b], int'($urandom_range(dmax, dmin)), fok, fdrop); ok &= fok; dropped |= fdrop;
      if (inject && b == 0) begin
        @(negedge i_clk);
        i_en_msg = 1'b1; i_msg = rnd128(); i_start = 1'b1; i_len_msg = $urandom;
        @(negedge i_clk);
        i_en_msg = 1'b0; i_start = 1'b0;
      end
    end
    cyc = 0;
    while (!o_done && cyc < 100) begin @(negedge i_clk); cyc++; end
    if (!o_done) ok = 1'b0;
    else begin
      tag = o_tag;
      @(negedge i_clk);
      one_pulse = !o_done;
    end
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    n_chk++; if (o_rqst_msg !== 1'b0) $display("FAIL reset_rqst: got %b want 0", o_rqst_msg); else n_pass++;
    n_chk++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else n_pass++;
    n_chk++; if (o_tag !== 128'd0) $display("FAIL reset_tag: got %h want 0", o_tag); else n_pass++;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_rfc();
    logic [127:0] tag; bit ok, dr, one; int rq0;
    load_rfc();
    rq0 = rq_rise;
    run_tag(RFC_R, RFC_S, 34, 1, 3, 1'b0, tag, ok, dr, one);
    n_chk++; if (ok !== 1'b1) $display("FAIL rfc_timeout: handshake or done wait expired"); else n_pass++;
    n_chk++; if (tag !== RFC_TAG) $display("FAIL rfc_tag: got %h want %h", tag, RFC_TAG); else n_pass++;
    n_chk++; if (rq_rise - rq0 !== 5) $display("FAIL rfc_requests: got %0d want 5", rq_rise - rq0); else n_pass++;
    n_chk++; if (one !== 1'b1) $display("FAIL rfc_done_width: done not a single-cycle pulse"); else n_pass++;
  endtask

  task automatic test_slow();
    logic [127:0] tag; bit ok, dr, one; int rq0;
    load_rfc();
    rq0 = rq_rise;
    run_tag(RFC_R, RFC_S, 34, 20, 20, 1'b0, tag, ok, dr, one);
    n_chk++; if (tag !== RFC_TAG) $display("FAIL slow_tag: got %h want %h", tag, RFC_TAG); else n_pass++;
    n_chk++; if (dr !== 1'b0) $display("FAIL slow_rqst_held: request dropped while waiting"); else n_pass++;
    n_chk++; if (rq_rise - rq0 !== 5) $display("FAIL slow_requests: got %0d want 5", rq_rise - rq0); else n_pass++;
  endtask

  task automatic test_len0();
    logic [127:0] tag; bit ok, dr, one; int rq0;
    rq0 = rq_rise;
    run_tag(RFC_R, RFC_S, 0, 1, 2, 1'b0, tag, ok, dr, one);
    n_chk++; if (tag !== RFC_S) $display("FAIL len0_tag: got %h want %h", tag, RFC_S); else n_pass++;
    n_chk++; if (rq_rise - rq0 !== 2) $display("FAIL len0_requests: got %0d want 2", rq_rise - rq0); else n_pass++;
  endtask

  task automatic test_clamp();
    logic [127:0] tag, exp; bit ok, dr, one;
    wbuf[0] = '0;
    exp = model_tag('1, '0, 16);
    run_tag('1, '0, 16, 0, 2, 1'b0, tag, ok, dr, one);
    n_chk++; if (tag !== exp) $display("FAIL clamp_tag: got %h want %h", tag, exp); else n_pass++;
  endtask

  task automatic test_ignored();
    logic [127:0] tag; bit ok, dr, one; int rq0, d0;
    load_rfc();
    rq0 = rq_rise; d0 = done_cnt;
    run_tag(RFC_R, RFC_S, 34, 1, 3, 1'b1, tag, ok, dr, one);
    repeat (5) @(negedge i_clk);
    n_chk++; if (tag !== RFC_TAG) $display("FAIL ignored_tag: got %h want %h", tag, RFC_TAG); else n_pass++;
    n_chk++; if (rq_rise - rq0 !== 5) $display("FAIL ignored_requests: got %0d want 5", rq_rise - rq0); else n_pass++;
    n_chk++; if (done_cnt - d0 !== 1) $display("FAIL ignored_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] tag; bit ok, dr, one;
    load_rfc();
    start_run(34);
    feed_word(RFC_R, 1, ok, dr);
    feed_word(RFC_S, 1, ok, dr);
    feed_word(wbuf[0], 1, ok, dr);
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    n_chk++; if (o_rqst_msg !== 1'b0) $display("FAIL midrst_rqst: got %b want 0", o_rqst_msg); else n_pass++;
    n_chk++; if (o_done !== 1'b0) $display("FAIL midrst_done: got %b want 0", o_done); else n_pass++;
    n_chk++; if (o_tag !== 128'd0) $display("FAIL midrst_tag: got %h want 0", o_tag); else n_pass++;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (3) @(negedge i_clk);
    n_chk++; if (o_rqst_msg !== 1'b0) $display("FAIL midrst_idle: got rqst %b want 0", o_rqst_msg); else n_pass++;
    run_tag(RFC_R, RFC_S, 34, 1, 3, 1'b0, tag, ok, dr, one);
    n_chk++; if (tag !== RFC_TAG) $display("FAIL midrst_rerun_tag: got %h want %h", tag, RFC_TAG); else n_pass++;
  endtask

  // Runs start in the cycle right after o_done, no idle gap in between.
  task automatic test_random_b2b();
    int lens [8] = '{16, 32, 1, 15, 17, 48, 0, 0};
    logic [127:0] tag, exp, r, s; bit ok, dr, one; int rq0, len;
    lens[6] = int'($urandom_range(100, 2));
    lens[7] = int'($urandom_range(200, 50));
    for (int t = 0; t < 8; t++) begin
      len = lens[t];
      r = rnd128(); s = rnd128();
      for (int b = 0; b < 16; b++) wbuf[b] = rnd128();
      exp = model_tag(r, s, len);
      rq0 = rq_rise;
      run_tag(r, s, len, 0, 3, 1'b0, tag, ok, dr, one);
      n_chk++; if (tag !== exp) $display("FAIL rand%0d_tag len=%0d: got %h want %h", t, len, tag, exp); else n_pass++;
      n_chk++; if (rq_rise - rq0 !== 2 + (len + 15) / 16)
        $display("FAIL rand%0d_requests: got %0d want %0d", t, rq_rise - rq0, 2 + (len + 15) / 16);
      else n_pass++;
      n_chk++; if (one !== 1'b1) $display("FAIL rand%0d_done: done missing or wider than one cycle", t); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rfc();
    test_slow();
    test_len0();
    test_clamp();
    test_ignored();
    test_reset_mid();
    test_random_b2b();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
